// File: rtl/seq_pkg.sv
// Shared types and constants for the cpu program sequencer.
package seq_pkg;

  localparam int WORD_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam logic [2:0] HALT_OPCODE = 3'b111;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } seq_state_e;

  // True when the instruction word carries the HALT opcode.
  function automatic logic is_halt(input logic [WORD_W-1:0] word);
    return (word[OPC_MSB:OPC_LSB] == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/instr_buf.sv
// Instruction storage: synchronous write port, combinational read port.
// Contents are deliberately not reset; the program survives a sequencer reset.
module instr_buf
  import seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Store a program word when the write port is enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Program sequencer in front of the cpu: issues buffered instructions one at
// a time (load IR, pulse s, wait busy, wait idle), captures result and flags,
// and stops at program length, a HALT opcode, or a cpu-wait timeout.
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          go,
  input  logic          cpu_w,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic [15:0]   last_out,
  output logic [2:0]    last_flags,
  output logic [AW:0]   instr_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  // FSM state
  seq_state_e state_q, state_d;

  // Run bookkeeping
  logic            go_q;
  logic [AW:0]     len_q, len_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [15:0]     last_out_q, last_out_d;
  logic [2:0]      last_flags_q, last_flags_d;
  logic            halted_q, halted_d;

  // Registered outputs
  logic [15:0]     cpu_in_q, cpu_in_d;
  logic            cpu_load_q, cpu_load_d;
  logic            cpu_s_q, cpu_s_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Decoded conditions
  logic            start_s;
  logic            accept_s;
  logic            retire_s;
  logic            tmo_hit_s;
  logic            last_instr_s;
  logic            buf_we_s;
  logic [15:0]     rd_data_s;

  assign start_s      = go & ~go_q;
  assign accept_s     = start_s & cpu_w &
                        ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign retire_s     = (state_q == WAIT_DONE) & cpu_w;
  assign tmo_hit_s    = (tmo_q == TMO_LAST);
  assign last_instr_s = ((cnt_q + CNT_ONE) == len_q);
  assign buf_we_s     = prog_we & ~busy_q;

  // The read port follows the next pc: on entry to FETCH it yields the word to
  // issue, and while in FETCH (pc stable) it yields mem[pc] for the HALT check.
  instr_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we_s),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_d),
    .rdata_o (rd_data_s)
  );

  // State register and go edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
    end
  end

  // Next-state logic; also tracks whether the run ended on a HALT word.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (accept_s) begin
          halted_d = 1'b0;
          if (prog_len == {(AW+1){1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = state_q;
        end
      end
      FETCH: begin
        if (is_halt(rd_data_s)) begin
          state_d  = DONE;
          halted_d = 1'b1;
        end else begin
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!cpu_w) begin
          state_d = WAIT_DONE;
        end else if (tmo_hit_s) begin
          state_d = ERROR;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (cpu_w) begin
          if (last_instr_s) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end else if (tmo_hit_s) begin
          state_d = ERROR;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // pc, instruction count, run length and result capture.
  always_comb begin
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    last_out_d   = last_out_q;
    last_flags_d = last_flags_q;
    if (accept_s) begin
      pc_d  = {AW{1'b0}};
      cnt_d = {(AW+1){1'b0}};
      len_d = prog_len;
    end else if (retire_s) begin
      pc_d         = pc_q + PC_ONE;
      cnt_d        = cnt_q + CNT_ONE;
      last_out_d   = cpu_out;
      last_flags_d = {cpu_N, cpu_V, cpu_Z};
    end else begin
      pc_d = pc_q;
    end
  end

  // Timeout counter: runs only while waiting for the awaited cpu_w level.
  always_comb begin
    tmo_d = {TW{1'b0}};
    case (state_q)
      WAIT_BUSY: begin
        if (cpu_w) begin
          tmo_d = tmo_q + TMO_ONE;
        end else begin
          tmo_d = {TW{1'b0}};
        end
      end
      WAIT_DONE: begin
        if (!cpu_w) begin
          tmo_d = tmo_q + TMO_ONE;
        end else begin
          tmo_d = {TW{1'b0}};
        end
      end
      default: begin
        tmo_d = {TW{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    cpu_load_d = (state_d == FETCH) && !is_halt(rd_data_s);
    cpu_s_d    = (state_d == START);
    busy_d     = (state_d == FETCH) || (state_d == START) ||
                 (state_d == WAIT_BUSY) || (state_d == WAIT_DONE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERROR);
    if (cpu_load_d) begin
      cpu_in_d = rd_data_s;
    end else begin
      cpu_in_d = cpu_in_q;
    end
  end

  // Run bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= {AW{1'b0}};
      cnt_q        <= {(AW+1){1'b0}};
      len_q        <= {(AW+1){1'b0}};
      tmo_q        <= {TW{1'b0}};
      last_out_q   <= 16'h0000;
      last_flags_q <= 3'b000;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      tmo_q        <= tmo_d;
      last_out_q   <= last_out_d;
      last_flags_q <= last_flags_d;
      halted_q     <= halted_d;
    end
  end

  // Output registers toward the cpu and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_in_q   <= 16'h0000;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cpu_in_q   <= cpu_in_d;
      cpu_load_q <= cpu_load_d;
      cpu_s_q    <= cpu_s_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cpu_in      = cpu_in_q;
  assign cpu_load    = cpu_load_q;
  assign cpu_s       = cpu_s_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign pc          = pc_q;
  assign last_out    = last_out_q;
  assign last_flags  = last_flags_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Program sequencer that sits directly upstream of the cpu block and drives its instruction interface (in, load, s), observing its w, out and N/V/Z.
- Holds a small instruction buffer, loaded through a write port.
- On go, issues instructions to the cpu one at a time: load the IR, pulse s, wait for the cpu to go busy and return to wait.
- Captures each result and its flags; stops at program length, a HALT opcode, or a timeout.

Parameters:
DEPTH, 16, number of 16-bit instruction words in the buffer
AW, 4, address width, equal to clog2(DEPTH)
TIMEOUT, 64, maximum cycles spent in any single cpu-wait state before error

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (reset=0 resets the block)
prog_we  input  1  instruction buffer write enable; ignored while busy=1
prog_addr  input  AW  instruction buffer write address
prog_data  input  16  instruction word to write
prog_len  input  AW+1  number of instructions to run (0..DEPTH); sampled on start
go  input  1  run request; a rising edge starts a run
cpu_w  input  1  cpu waiting/idle indication
cpu_out  input  16  cpu datapath result
cpu_N, cpu_V, cpu_Z  input  1 each  cpu status flags
cpu_in  output  16  instruction word presented to the cpu
cpu_load  output  1  one-cycle IR load strobe to the cpu
cpu_s  output  1  one-cycle start strobe to the cpu
busy  output  1  high from start until DONE or ERROR
done  output  1  run completed normally; held until next start
halted  output  1  run ended on a HALT opcode; held until next start
err  output  1  timeout occurred; held until next start
pc  output  AW  index of current/next instruction
last_out  output  16  cpu_out captured at the last instruction completion
last_flags  output  3  {N,V,Z} captured with last_out
instr_count  output  AW+1  instructions completed in the current run

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs and registers are 0, including pc, instr_count, last_out, last_flags, the timeout counter and the go edge register. Buffer contents are not reset.
- go is registered; start = go & ~go_q.
- A start is accepted only in IDLE, DONE or ERROR, and only when cpu_w=1; otherwise it is ignored.
- On accepted start:
  - pc=0, instr_count=0; done, halted and err are cleared.
  - len_q <= prog_len; busy=1.
  - If prog_len=0, go to DONE; otherwise go to FETCH.
- FETCH (1 cycle):
  - If mem[pc][15:13]==3'b111 (HALT): go to DONE, halted=1, nothing issued.
  - Otherwise: cpu_in=mem[pc], cpu_load=1, go to START.
- START (1 cycle): cpu_s=1; cpu_in is held at mem[pc]; go to WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY: wait for cpu_w=0, then go to WAIT_DONE and clear the counter.
- WAIT_DONE: wait for cpu_w=1. On that edge:
  - last_out <= cpu_out, last_flags <= {cpu_N,cpu_V,cpu_Z}.
  - instr_count++, pc++.
  - If instr_count+1==len_q, go to DONE; else go to FETCH.
- Timeout: in WAIT_BUSY or WAIT_DONE, when the counter reaches TIMEOUT-1 without the awaited cpu_w value, go to ERROR with err=1. pc and instr_count are frozen.
- DONE and ERROR: busy=0; done or err is held; a new accepted start restarts the run.
- Outside FETCH and START: cpu_load=0 and cpu_s=0. cpu_in holds its last value.
- Minimum cost per instruction is 4 cycles plus cpu execution latency.
- Buffer writes: synchronous on clk when prog_we=1 and busy=0. A write attempted while busy is dropped.
- pc wraps naturally at DEPTH only when prog_len=DEPTH, and only after the final instruction; it is never used past len_q.
- go held high does not retrigger. go falling mid-run has no effect.
- Reset asserted mid-run aborts immediately to IDLE with all strobes low.

Decomposition:
- Package seq_pkg:
  - State enum: IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE, DONE, ERROR.
  - HALT_OPCODE = 3'b111.
  - Opcode field position [15:13].
- Sub-module instr_buf: DEPTH x 16 storage, synchronous write, combinational read.
- cpu_sequencer holds the FSM, counters and capture registers.

Test Plan:
- Reset with go=1, cpu_w=0 -> all outputs 0, state IDLE; go rising while cpu_w=0 -> no cpu_load.
- Write 16'hD105 (MOV R1,#5) and 16'hD203 (MOV R2,#3) at 0..1, prog_len=2, go; cpu model with 3-cycle latency:
  - cpu_load then cpu_s seen twice, each strobe exactly 1 cycle.
  - done=1, instr_count=2, pc=2, busy=0.
- prog_len=3 with buffer word 1 = 16'hE000 -> one instruction issued, then halted=1, done=1, instr_count=1, no second cpu_load.
- cpu model whose cpu_w never returns to 1 -> err=1 exactly TIMEOUT cycles after entering WAIT_DONE, busy=0, instr_count unchanged; next go clears err.
- prog_len=0, go -> done=1 next cycle, zero cpu_load/cpu_s pulses.
- prog_we=1 writing 16'hFFFF to addr 0 during a run -> mem[0] unchanged; reset pulse mid-WAIT_DONE -> immediately IDLE, all outputs 0.
